activation_pipe: RTL

ACTIVATION_PIPE -- requirements
Module: activation_pipe

---
 rtl/activation_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/activation_pipe.sv
// Per-lane activation (pass / ReLU / leaky ReLU / leaky-ReLU derivative) on LANES signed fixed-point words.
// Two-stage valid/ready pipeline: S1 holds operands and full products, S2 holds rounded, saturated results.
module activation_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [1:0]                mode_in,
    input  logic signed [WIDTH-1:0]   leak_in,
    input  logic [LANES*WIDTH-1:0]    data_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [LANES*WIDTH-1:0]    data_out,
    output logic [LANES-1:0]          sat_out
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0]    MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    RND  = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    logic                    advance;
    logic                    s1_vld;
    logic [1:0]              s1_mode;
    logic signed [WIDTH-1:0] s1_leak;
    logic signed [WIDTH-1:0] s1_x    [LANES];
    logic signed [PW-1:0]    s1_prod [LANES];

    logic [LANES*WIDTH-1:0]  res;
    logic [LANES-1:0]        sat;
    logic signed [PW-1:0]    rnd;
    logic signed [WIDTH-1:0] lane;

    // Stall is purely a function of the output register, never of valid_in.
    assign advance   = !valid_out || ready_in;
    assign ready_out = advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_mode <= '0;
            s1_leak <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_x[i]    <= '0;
                s1_prod[i] <= '0;
            end
        end else if (advance) begin
            s1_vld  <= valid_in;
            s1_mode <= mode_in;
            s1_leak <= leak_in;
            for (int i = 0; i < LANES; i++) begin
                s1_x[i]    <= $signed(data_in[i*WIDTH +: WIDTH]);
                s1_prod[i] <= PW'($signed(data_in[i*WIDTH +: WIDTH])) * PW'(leak_in);
            end
        end
    end

    always_comb begin
        res  = '0;
        sat  = '0;
        rnd  = '0;
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            rnd = (s1_prod[i] + RND) >>> FRAC;
            case (s1_mode)
                2'd0: lane = s1_x[i];
                2'd1: lane = s1_x[i][WIDTH-1] ? '0 : s1_x[i];
                2'd2: begin
                    if (!s1_x[i][WIDTH-1]) begin
                        lane = s1_x[i];
                    end else if (rnd > MAXV) begin
                        lane   = MAXV[WIDTH-1:0];
                        sat[i] = 1'b1;
                    end else if (rnd < MINV) begin
                        lane   = MINV[WIDTH-1:0];
                        sat[i] = 1'b1;
                    end else begin
                        lane = rnd[WIDTH-1:0];
                    end
                end
                default: lane = s1_x[i][WIDTH-1] ? s1_leak : ONE;
            endcase
            res[i*WIDTH +: WIDTH] = lane;
        end
    end

    // Bubbles load zeros so the outputs read as 0 whenever valid_out is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sat_out   <= '0;
        end else if (advance) begin
            valid_out <= s1_vld;
            data_out  <= s1_vld ? res : '0;
            sat_out   <= s1_vld ? sat : '0;
        end
    end
endmodule
